tour_cmd_sequencer: RTL

//  Queues up to DEPTH 16-bit Knight commands (CAL_GYRO, move, move-with-fanfare) and issues them one at a

---
 rtl/tour_cmd_sequencer_if.sv | 11 +
 rtl/tour_cmd_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_sequencer_if.sv
// RemoteComm link between the tour command sequencer (master) and the UART transmitter side (slave).
interface tour_cmd_sequencer_if;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (output cmd, snd_cmd, input cmd_snt, resp_rdy, resp);
  modport slave  (input cmd, snd_cmd, output cmd_snt, resp_rdy, resp);
endinterface

// File: rtl/tour_cmd_sequencer.sv
// Host-side Knight command sequencer: queues commands in a FIFO and issues them one at a time over
// RemoteComm, retrying on response timeout and halting on a negative response.
module tour_cmd_sequencer #(
  parameter int          DEPTH        = 8,
  parameter logic [23:0] TIMEOUT_CLKS = 24'd4000000,
  parameter int          MAX_RETRY    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [15:0]                  wr_cmd,
  input  logic                         start,
  input  logic                         abort,
  output logic                         full,
  output logic                         empty,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [7:0]                   n_done,
  tour_cmd_sequencer_if.master         link
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SEND      = 3'd2;
  localparam logic [2:0] ST_WAIT_SNT  = 3'd3;
  localparam logic [2:0] ST_WAIT_RESP = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_ERR       = 3'd6;

  localparam logic [7:0] RESP_ACK = 8'hA5;

  logic [15:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] count_r;
  logic [PW-1:0] count_nxt_s;
  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic [15:0]   cmd_r;
  logic [23:0]   timer_r;
  logic [7:0]    retry_cnt_r;
  logic [7:0]    n_done_r;
  logic [1:0]    err_code_r;
  logic          snd_cmd_r;
  logic          done_r;
  logic          busy_r;
  logic          err_r;
  logic          full_r;
  logic          empty_r;

  logic ack_s;
  logic nak_s;
  logic tmo_s;
  logic retry_ok_s;
  logic pop_s;
  logic push_s;
  logic fifo_full_s;
  logic start_acc_s;

  assign fifo_full_s = (count_r == PW'(DEPTH));
  assign ack_s       = (state_r == ST_WAIT_RESP) && link.resp_rdy && (link.resp == RESP_ACK);
  assign nak_s       = (state_r == ST_WAIT_RESP) && link.resp_rdy && (link.resp != RESP_ACK);
  // A response arriving on the timeout cycle takes precedence over the retry.
  assign tmo_s       = (state_r == ST_WAIT_RESP) && !link.resp_rdy && (timer_r == (TIMEOUT_CLKS - 24'd1));
  assign retry_ok_s  = (retry_cnt_r < 8'(MAX_RETRY));
  assign pop_s       = ack_s && !abort;
  assign push_s      = wr_en && (!fifo_full_s || pop_s) && !abort;
  assign start_acc_s = start && !abort && ((state_r == ST_IDLE) || (state_r == ST_ERR));
  assign count_nxt_s = abort ? {PW{1'b0}}
                             : (count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s});

  // Next-state logic for the issue FSM; abort overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s = (count_r == {PW{1'b0}}) ? ST_DONE : ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD:     state_nxt_s = ST_SEND;
        ST_SEND:     state_nxt_s = ST_WAIT_SNT;
        ST_WAIT_SNT: begin
          if (link.cmd_snt) begin
            state_nxt_s = ST_WAIT_RESP;
          end else begin
            state_nxt_s = ST_WAIT_SNT;
          end
        end
        ST_WAIT_RESP: begin
          if (ack_s) begin
            state_nxt_s = (count_nxt_s != {PW{1'b0}}) ? ST_LOAD : ST_DONE;
          end else if (nak_s) begin
            state_nxt_s = ST_ERR;
          end else if (tmo_s) begin
            state_nxt_s = retry_ok_s ? ST_SEND : ST_ERR;
          end else begin
            state_nxt_s = ST_WAIT_RESP;
          end
        end
        ST_DONE: state_nxt_s = ST_IDLE;
        ST_ERR: begin
          if (start) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_ERR;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FIFO storage; entries need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_cmd;
    end
  end

  // FIFO pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {PW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (abort) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == PW'(DEPTH));
      empty_r <= (count_nxt_s == {PW{1'b0}});
    end
  end

  // FSM state, registered status outputs, command latch, timer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      snd_cmd_r   <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      cmd_r       <= 16'h0000;
      timer_r     <= 24'd0;
      retry_cnt_r <= 8'd0;
      n_done_r    <= 8'd0;
      err_code_r  <= 2'd0;
    end else begin
      state_r   <= state_nxt_s;
      snd_cmd_r <= (state_nxt_s == ST_SEND);
      done_r    <= (state_nxt_s == ST_DONE);
      err_r     <= (state_nxt_s == ST_ERR);
      busy_r    <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE) && (state_nxt_s != ST_ERR);

      if (state_r == ST_LOAD) cmd_r <= mem_r[rd_ptr_r[AW-1:0]];

      if (state_r == ST_LOAD) begin
        retry_cnt_r <= 8'd0;
      end else if (tmo_s && retry_ok_s) begin
        retry_cnt_r <= retry_cnt_r + 8'd1;
      end

      if ((state_r == ST_WAIT_SNT) && link.cmd_snt) begin
        timer_r <= 24'd0;
      end else if (state_r == ST_WAIT_RESP) begin
        timer_r <= timer_r + 24'd1;
      end

      if (abort || start_acc_s) begin
        err_code_r <= 2'd0;
      end else if (nak_s) begin
        err_code_r <= 2'd1;
      end else if (tmo_s && !retry_ok_s) begin
        err_code_r <= 2'd2;
      end

      if (start_acc_s) begin
        n_done_r <= 8'd0;
      end else if (pop_s && (n_done_r != 8'd255)) begin
        n_done_r <= n_done_r + 8'd1;
      end
    end
  end

  assign link.cmd     = cmd_r;
  assign link.snd_cmd = snd_cmd_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign err_code     = err_code_r;
  assign n_done       = n_done_r;

endmodule
